// File: rtl/agp32_mem_responder.sv
// agp32_mem_responder
//   Memory-side responder for the agp32 processor command interface. A
//   single-port word RAM serves instruction fetch, data read, word write and
//   byte-strobed write, with a power-on zero-fill, fixed access latency and
//   sticky error reporting.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   command[2:0]     0 idle, 1 fetch, 2 read, 3 write, 4 interrupt-sync
//   PC[31:0]         instruction byte address (fetched on every command)
//   data_addr[31:0]  data byte address for read/write
//   data_wdata[31:0] write data
//   data_wstrb[3:0]  byte enables for write
//   ready            idle and results valid
//   data_rdata[31:0] word returned by the last read
//   inst_rdata[31:0] word at PC of the last completed command
//   mem_start_ready  zero-fill complete
//   error[1:0]       0 ok, 1 out of range, 2 misaligned, 3 illegal command
module agp32_mem_responder #(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  command,
  input  logic [31:0] PC,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_wstrb,
  output logic        ready,
  output logic [31:0] data_rdata,
  output logic [31:0] inst_rdata,
  output logic        mem_start_ready,
  output logic [1:0]  error
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = 4;
  localparam logic [31:0]   ADDR_LIMIT = 32'(DEPTH * 4);
  localparam logic [AW-1:0] FILL_LAST  = AW'(DEPTH - 1);
  localparam logic [CW-1:0] LAT_M1     = CW'(LATENCY - 1);

  localparam logic [2:0] CMD_READ  = 3'd2;
  localparam logic [2:0] CMD_WRITE = 3'd3;
  localparam logic [2:0] CMD_LAST  = 3'd4;

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_BUSY,
    S_ERR
  } state_e;

  state_e        state_q;
  logic [AW-1:0] fill_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    cmd_q;
  logic [31:0]   pc_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    wstrb_q;

  logic [31:0]   mem_q [DEPTH];

  logic          done_c;
  logic [1:0]    err_code_c;
  logic [AW-1:0] pc_idx_c;
  logic [AW-1:0] dat_idx_c;

  logic [3:0]    mem_we_c;
  logic [AW-1:0] mem_widx_c;
  logic [31:0]   mem_wdata_c;

  // Completion decode: error classification in priority order, full 32-bit compares.
  always_comb begin
    done_c     = (state_q == S_BUSY) && (cnt_q == '0);
    pc_idx_c   = pc_q[AW+1:2];
    dat_idx_c  = addr_q[AW+1:2];
    err_code_c = 2'd0;
    if (cmd_q > CMD_LAST) begin
      err_code_c = 2'd3;
    end else if ((pc_q >= ADDR_LIMIT) ||
                 (((cmd_q == CMD_READ) || (cmd_q == CMD_WRITE)) && (addr_q >= ADDR_LIMIT))) begin
      err_code_c = 2'd1;
    end else if ((pc_q[1:0] != 2'b00) ||
                 ((cmd_q == CMD_WRITE) && (wstrb_q == 4'hF) && (addr_q[1:0] != 2'b00))) begin
      err_code_c = 2'd2;
    end
  end

  // Single write port: zero-fill during INIT, otherwise a good write completion.
  always_comb begin
    mem_we_c    = 4'h0;
    mem_widx_c  = fill_q;
    mem_wdata_c = 32'h0;
    if (state_q == S_INIT) begin
      mem_we_c = 4'hF;
    end else if (done_c && (err_code_c == 2'd0) && (cmd_q == CMD_WRITE)) begin
      mem_we_c    = wstrb_q;
      mem_widx_c  = dat_idx_c;
      mem_wdata_c = wdata_q;
    end
  end

  // RAM array, byte-enabled, no reset (contents rebuilt by the INIT fill).
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (mem_we_c[b]) begin
        mem_q[mem_widx_c][8*b +: 8] <= mem_wdata_c[8*b +: 8];
      end
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_INIT;
      fill_q          <= '0;
      cnt_q           <= '0;
      cmd_q           <= 3'd0;
      pc_q            <= 32'h0;
      addr_q          <= 32'h0;
      wdata_q         <= 32'h0;
      wstrb_q         <= 4'h0;
      ready           <= 1'b0;
      data_rdata      <= 32'h0;
      inst_rdata      <= 32'h0;
      mem_start_ready <= 1'b0;
      error           <= 2'd0;
    end else begin
      case (state_q)
        S_INIT: begin
          fill_q <= fill_q + AW'(1);
          if (fill_q == FILL_LAST) begin
            mem_start_ready <= 1'b1;
            ready           <= 1'b1;
            state_q         <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (command != 3'd0) begin
            cmd_q   <= command;
            pc_q    <= PC;
            addr_q  <= data_addr;
            wdata_q <= data_wdata;
            wstrb_q <= data_wstrb;
            ready   <= 1'b0;
            cnt_q   <= LAT_M1;
            state_q <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else if (err_code_c != 2'd0) begin
            error   <= err_code_c;
            state_q <= S_ERR;
          end else begin
            // Reads see pre-write contents; the write lands in the RAM on this same edge.
            inst_rdata <= mem_q[pc_idx_c];
            if (cmd_q == CMD_READ) begin
              data_rdata <= mem_q[dat_idx_c];
            end
            ready   <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: begin
          // S_ERR: terminal until reset.
          state_q <= S_ERR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_agp32_mem_responder.sv
// Self-checking bench for agp32_mem_responder (DEPTH=16, LATENCY=2).
module tb_agp32_mem_responder;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned LAT   = 2;
  localparam logic [31:0] LIMIT = 32'(DEPTH * 4);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  command = 3'd0;
  logic [31:0] PC = 32'h0;
  logic [31:0] data_addr = 32'h0;
  logic [31:0] data_wdata = 32'h0;
  logic [3:0]  data_wstrb = 4'h0;
  logic        ready;
  logic [31:0] data_rdata;
  logic [31:0] inst_rdata;
  logic        mem_start_ready;
  logic [1:0]  error;

  agp32_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .command(command), .PC(PC),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_wstrb(data_wstrb),
    .ready(ready), .data_rdata(data_rdata), .inst_rdata(inst_rdata),
    .mem_start_ready(mem_start_ready), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rdata;
    logic [31:0] inst;
    logic [1:0]  err;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model_mem [DEPTH];
  logic [31:0] model_rdata;
  logic [31:0] model_inst;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
    model_rdata = 32'h0;
    model_inst  = 32'h0;
    sb_q.delete();
  endtask

  // Reset pulse, then wait for the zero-fill to finish.
  task automatic apply_reset(input bit chk);
    int cyc;
    @(negedge clk);
    rst_n = 1'b0; command = 3'd0;
    repeat (2) @(negedge clk);
    if (chk) begin
      n_checks++;
      if ({ready, mem_start_ready, error} !== 4'b0 || data_rdata !== 32'h0 || inst_rdata !== 32'h0)
        $display("FAIL reset_values: ready=%b msr=%b err=%0d rdata=%h inst=%h, want all zero",
                 ready, mem_start_ready, error, data_rdata, inst_rdata);
      else n_pass++;
    end
    rst_n = 1'b1;
    cyc = 0;
    while (!mem_start_ready && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (cyc !== DEPTH) $display("FAIL init_length: got %0d cycles, want %0d", cyc, DEPTH);
    else n_pass++;
    if (chk) begin
      n_checks++;
      if (ready !== 1'b1 || error !== 2'd0)
        $display("FAIL init_ready: ready=%b err=%0d, want ready=1 err=0", ready, error);
      else n_pass++;
    end
    model_clear();
  endtask

  // Issue one command from IDLE (called at a negedge), score its completion.
  task automatic issue(input logic [2:0] cmd, input logic [31:0] pc, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] ws, input string name);
    exp_t e, got;
    int   low;
    e.rdata = model_rdata;
    e.inst  = model_inst;
    e.err   = 2'd0;
    if (cmd > 3'd4) e.err = 2'd3;
    else if (pc >= LIMIT || ((cmd == 3'd2 || cmd == 3'd3) && addr >= LIMIT)) e.err = 2'd1;
    else if (pc[1:0] != 2'b00 || (cmd == 3'd3 && ws == 4'hF && addr[1:0] != 2'b00)) e.err = 2'd2;
    if (e.err == 2'd0) begin
      e.inst = model_mem[int'(pc[5:2])];
      if (cmd == 3'd2) e.rdata = model_mem[int'(addr[5:2])];
      if (cmd == 3'd3)
        for (int b = 0; b < 4; b++)
          if (ws[b]) model_mem[int'(addr[5:2])][8*b +: 8] = wd[8*b +: 8];
      model_rdata = e.rdata;
      model_inst  = e.inst;
    end
    sb_q.push_back(e);
    command = cmd; PC = pc; data_addr = addr; data_wdata = wd; data_wstrb = ws;
    low = 0;
    @(negedge clk);
    command = 3'd0;
    while (!ready && error == 2'd0 && low < 40) begin
      low++;
      @(negedge clk);
    end
    got = sb_q.pop_front();
    n_checks++;
    if (low !== LAT) $display("FAIL %s_latency: ready low %0d cycles, want %0d", name, low, LAT);
    else n_pass++;
    n_checks++;
    if (error !== got.err || ready !== (got.err == 2'd0))
      $display("FAIL %s_status: err=%0d ready=%b, want err=%0d ready=%b",
               name, error, ready, got.err, got.err == 2'd0);
    else n_pass++;
    n_checks++;
    if (data_rdata !== got.rdata || inst_rdata !== got.inst)
      $display("FAIL %s_data: rdata=%h inst=%h, want rdata=%h inst=%h",
               name, data_rdata, inst_rdata, got.rdata, got.inst);
    else n_pass++;
  endtask

  // Commands after an error must be ignored and the code must hold.
  task automatic check_sticky(input logic [1:0] code, input string name);
    logic [31:0] inst_before;
    inst_before = inst_rdata;
    command = 3'd1; PC = 32'h0;
    @(negedge clk);
    command = 3'd0;
    repeat (6) @(negedge clk);
    n_checks++;
    if (ready !== 1'b0 || error !== code || inst_rdata !== inst_before)
      $display("FAIL %s_sticky: ready=%b err=%0d inst=%h, want ready=0 err=%0d inst=%h",
               name, ready, error, inst_rdata, code, inst_before);
    else n_pass++;
  endtask

  task automatic test_reset();
    apply_reset(1'b1);
  endtask

  task automatic test_zero_read();
    issue(3'd2, 32'h0, 32'h3C, 32'h0, 4'h0, "zero_rd_hi");
    issue(3'd2, 32'h4, 32'h14, 32'h0, 4'h0, "zero_rd_mid");
  endtask

  task automatic test_write_read();
    issue(3'd3, 32'h0, 32'h08, 32'hCAFEF00D, 4'hF, "wr_word2");
    issue(3'd3, 32'h8, 32'h10, 32'hDEADBEEF, 4'hF, "wr_word4");
    issue(3'd2, 32'h8, 32'h13, 32'h0, 4'h0, "rd_unaligned");
    n_checks++;
    if (data_rdata !== 32'hDEADBEEF || inst_rdata !== 32'hCAFEF00D)
      $display("FAIL rd_literal: rdata=%h inst=%h, want DEADBEEF CAFEF00D", data_rdata, inst_rdata);
    else n_pass++;
    issue(3'd1, 32'h10, 32'h0, 32'h0, 4'h0, "fetch_hold");
  endtask

  task automatic test_byte_write();
    issue(3'd3, 32'h0, 32'h10, 32'h11223344, 4'hF, "bw_base");
    issue(3'd3, 32'h0, 32'h11, 32'h0000AB00, 4'b0010, "bw_byte1");
    issue(3'd2, 32'h0, 32'h10, 32'h0, 4'h0, "bw_read");
    n_checks++;
    if (data_rdata !== 32'h1122AB44) $display("FAIL bw_literal: rdata=%h, want 1122AB44", data_rdata);
    else n_pass++;
    issue(3'd3, 32'h0, 32'h12, 32'hFFFFFFFF, 4'h0, "bw_nostrobe");
    issue(3'd2, 32'h0, 32'h10, 32'h0, 4'h0, "bw_reread");
    n_checks++;
    if (data_rdata !== 32'h1122AB44) $display("FAIL bw_noop_literal: rdata=%h, want 1122AB44", data_rdata);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [2:0]  cmd;
    logic [31:0] pc, addr, wd;
    logic [3:0]  ws;
    for (int i = 0; i < 10; i++) begin
      cmd  = 3'($urandom_range(1, 3));
      pc   = {26'h0, 4'($urandom_range(0, DEPTH - 1)), 2'b00};
      ws   = 4'($urandom);
      addr = {26'h0, 4'($urandom_range(0, DEPTH - 1)), 2'b00};
      if (cmd == 3'd2) addr[1:0] = 2'($urandom);
      wd   = $urandom;
      issue(cmd, pc, addr, wd, ws, "b2b");
    end
  endtask

  task automatic test_range_error();
    issue(3'd2, 32'h0, LIMIT, 32'h0, 4'h0, "range_rd");
    check_sticky(2'd1, "range");
  endtask

  task automatic test_misalign();
    issue(3'd3, 32'h0, 32'h4, 32'hA5A5A5A5, 4'hF, "mis_setup");
    issue(3'd3, 32'h0, 32'h6, 32'h12345678, 4'hF, "mis_write");
    n_checks++;
    if (dut.mem_q[1] !== 32'hA5A5A5A5)
      $display("FAIL mis_backdoor: mem[1]=%h, want A5A5A5A5", dut.mem_q[1]);
    else n_pass++;
    check_sticky(2'd2, "mis");
  endtask

  task automatic test_illegal();
    issue(3'd6, 32'h0, 32'h0, 32'h0, 4'h0, "illegal");
    check_sticky(2'd3, "illegal");
    apply_reset(1'b0);
    issue(3'd1, 32'h42, 32'h0, 32'h0, 4'h0, "range_over_mis");
  endtask

  task automatic test_reset_mid_write();
    command = 3'd3; PC = 32'h0; data_addr = 32'h20; data_wdata = 32'h5A5A5A5A; data_wstrb = 4'hF;
    @(negedge clk);
    command = 3'd0;
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ready !== 1'b0 || error !== 2'd0 || mem_start_ready !== 1'b0)
      $display("FAIL midrst_abort: ready=%b err=%0d msr=%b, want 0 0 0", ready, error, mem_start_ready);
    else n_pass++;
    apply_reset(1'b0);
    issue(3'd2, 32'h0, 32'h20, 32'h0, 4'h0, "midrst_read");
    n_checks++;
    if (data_rdata !== 32'h0 || error !== 2'd0)
      $display("FAIL midrst_lost: rdata=%h err=%0d, want 0 0", data_rdata, error);
    else n_pass++;
  endtask

  initial begin
    model_clear();
    test_reset();
    test_zero_read();
    test_write_read();
    test_byte_write();
    test_back_to_back();
    test_range_error();
    apply_reset(1'b0);
    test_misalign();
    apply_reset(1'b0);
    test_illegal();
    apply_reset(1'b0);
    test_reset_mid_write();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
